// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Fetch-stage front end. Owns the fetch PC, issues in-order imem
//               requests (req/gnt + rvalid) and buffers returned words for IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
    parameter int              FIFO_DEPTH = 2,
    parameter int              CNT_W      = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            inst_valid_o
);

    localparam int               c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [XLEN-1:0]  c_NOP     = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0]  c_PC_STEP = XLEN'(4);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   c_CREDITS = (CNT_W+1)'(FIFO_DEPTH);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_fifo_pc   [0:FIFO_DEPTH-1];
    logic [XLEN-1:0]    r_fifo_inst [0:FIFO_DEPTH-1];
    logic [XLEN-1:0]    r_tag       [0:FIFO_DEPTH-1];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_tag_rd;
    logic [c_PTR_W-1:0] r_tag_wr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   r_drop;

    logic [CNT_W:0]     w_credit_used;
    logic               w_req;
    logic               w_grant;
    logic               w_resp;
    logic               w_discard;
    logic               w_push;
    logic               w_valid;
    logic               w_pop;
    logic [CNT_W-1:0]   w_inflight_nxt;

    // A request is only issued when a buffer slot is guaranteed for its response.
    assign w_credit_used  = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_req          = !rst_i && !flush_i && (w_credit_used < c_CREDITS);
    assign w_grant        = w_req && imem_gnt_i;
    assign w_resp         = imem_rvalid_i && (r_inflight != '0);
    assign w_discard      = w_resp && (r_drop != '0);
    assign w_push         = w_resp && (r_drop == '0) && !flush_i;
    assign w_valid        = !rst_i && (r_count != '0);
    assign w_pop          = w_valid && !stall_i && !flush_i;
    assign w_inflight_nxt = r_inflight + CNT_W'(w_grant) - CNT_W'(w_resp);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_tag_rd   <= '0;
            r_tag_wr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (w_grant) begin
                r_tag_wr <= r_tag_wr + c_PTR_ONE;
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + c_PTR_ONE;
            end
            if (flush_i) begin
                // Everything still outstanding belongs to the old stream.
                r_fetch_pc <= redirect_pc_i;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_drop     <= w_inflight_nxt;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                end
                if (w_discard) begin
                    r_drop <= r_drop - c_CNT_ONE;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_tag[r_tag_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
            r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
        end
    end

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_fetch_pc;
    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? r_fifo_inst[r_rd_ptr] : c_NOP;
    assign pc_o         = w_valid ? r_fifo_pc[r_rd_ptr] : '0;

    a_rvalid_has_request: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (r_inflight != '0));

endmodule
`default_nettype wire
